// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave stream block: synchroniser reset
// values, FSM state encoding and the frame-length clamp.
package spi_pkg;

    // SS idles high, so its synchroniser resets to "deselected".
    // SCK and MOSI synchronisers reset to zero.
    localparam logic [1:0] SS_SYNC_RST   = 2'b11;
    localparam logic [1:0] SCK_SYNC_RST  = 2'b00;
    localparam logic [1:0] MOSI_SYNC_RST = 2'b00;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // A length of zero, or one above the maximum, selects the maximum.
    function automatic int unsigned clamp_len(
        input int unsigned len,
        input int unsigned max_len
    );
        return (len == 0 || len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Ports: i_data/i_valid/o_ready push side, o_data/o_valid/i_ready pop side,
// i_flush synchronous clear, o_level occupancy.
module spi_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             push, pop;

    assign o_ready = (cnt_q != LW'(DEPTH));
    assign o_valid = (cnt_q != '0);
    assign o_data  = mem_q[rd_q];
    assign o_level = cnt_q;

    // Each side only acts when its own condition is legal, so a push into
    // a full FIFO is dropped even while a pop happens in the same cycle.
    assign push = i_valid && o_ready;
    assign pop  = i_ready && o_valid;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (i_flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + AW'(1);
            if (pop)  rd_d = rd_q + AW'(1);
            if (push && !pop)      cnt_d = cnt_q + LW'(1);
            else if (pop && !push) cnt_d = cnt_q - LW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) mem_q[wr_q] <= i_data;
    end

endmodule

// File: rtl/spi_slave_stream.sv
// SPI slave with run-time CPOL/CPHA/bit order, programmable frame length
// and TX/RX FIFOs exposed as valid/ready streams.
// Ports: i_sck/i_mosi/i_ss_n/o_miso/o_miso_oe pins; i_cpol/i_cpha/i_lsb/
// i_frame_len mode; i_tx_* / o_rx_* streams; levels and event pulses.
module spi_slave_stream
    import spi_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1,
    localparam int FLW   = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sck,
    input  logic             i_mosi,
    input  logic             i_ss_n,
    output logic             o_miso,
    output logic             o_miso_oe,
    input  logic             i_reset,
    input  logic             i_cpol,
    input  logic             i_cpha,
    input  logic             i_lsb,
    input  logic [FLW-1:0]   i_frame_len,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    input  logic             i_rx_ready,
    output logic [LW-1:0]    o_tx_level,
    output logic [LW-1:0]    o_rx_level,
    output logic             o_tx_underrun,
    output logic             o_rx_overrun,
    output logic             o_frame_abort
);

    // Synchronisers plus a history flop for edge detection
    logic [1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic       sck_hist_q, ss_hist_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_sync_q  <= SCK_SYNC_RST;
            ss_sync_q   <= SS_SYNC_RST;
            mosi_sync_q <= MOSI_SYNC_RST;
            sck_hist_q  <= SCK_SYNC_RST[1];
            ss_hist_q   <= SS_SYNC_RST[1];
        end else begin
            sck_sync_q  <= {sck_sync_q[0], i_sck};
            ss_sync_q   <= {ss_sync_q[0], i_ss_n};
            mosi_sync_q <= {mosi_sync_q[0], i_mosi};
            sck_hist_q  <= sck_sync_q[1];
            ss_hist_q   <= ss_sync_q[1];
        end
    end

    logic sck_rise, sck_fall, ss_fall, ss_rise, mosi_s;
    assign sck_rise = sck_sync_q[1] & ~sck_hist_q;
    assign sck_fall = ~sck_sync_q[1] & sck_hist_q;
    assign ss_fall  = ~ss_sync_q[1] & ss_hist_q;
    assign ss_rise  = ss_sync_q[1] & ~ss_hist_q;
    assign mosi_s   = mosi_sync_q[1];

    // FSM and datapath state
    state_e           state_q, state_d;
    logic             cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [FLW-1:0]   len_q, len_d;
    logic [FLW-1:0]   cnt_q, cnt_d;
    logic             sampled_q, sampled_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] tx_word_q, tx_word_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic             miso_q, miso_d, oe_q, oe_d;
    logic             under_q, under_d, over_q, over_d;
    logic             abort_q, abort_d;

    // FIFO hookup
    logic [WIDTH-1:0] txf_data;
    logic             txf_valid, tx_pop;
    logic             rxf_ready, rx_push;
    logic [WIDTH-1:0] rx_next;

    logic [FLW-1:0]   len_eff, cnt_inc;
    logic [WIDTH-1:0] load_w;
    logic             sample_edge, shift_edge;

    assign len_eff = FLW'(clamp_len(32'(i_frame_len), 32'(WIDTH)));
    assign cnt_inc = cnt_q + FLW'(1);
    assign load_w  = txf_valid ? txf_data : '0;

    // Modes 0 and 3 sample on rising SCK, modes 1 and 2 on falling.
    assign sample_edge = (cpol_q ^ cpha_q) ? sck_fall : sck_rise;
    assign shift_edge  = (cpol_q ^ cpha_q) ? sck_rise : sck_fall;

    // Bit idx of the frame in transmit order
    function automatic logic pick(
        input logic [WIDTH-1:0] w,
        input logic             lsb,
        input logic [FLW-1:0]   len,
        input logic [FLW-1:0]   idx
    );
        logic [WIDTH-1:0] s;
        s = lsb ? (w >> idx) : (w >> (len - FLW'(1) - idx));
        return s[0];
    endfunction

    always_comb begin
        state_d   = state_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        sampled_d = sampled_q;
        done_d    = done_q;
        tx_word_d = tx_word_q;
        rx_sh_d   = rx_sh_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        under_d   = 1'b0;
        over_d    = 1'b0;
        abort_d   = 1'b0;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        rx_next   = rx_sh_q;

        unique case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d   = ST_ACTIVE;
                    cpol_d    = i_cpol;
                    cpha_d    = i_cpha;
                    lsb_d     = i_lsb;
                    len_d     = len_eff;
                    cnt_d     = '0;
                    sampled_d = 1'b0;
                    done_d    = 1'b0;
                    rx_sh_d   = '0;
                    oe_d      = 1'b1;
                    tx_pop    = txf_valid;
                    under_d   = ~txf_valid;
                    tx_word_d = load_w;
                    miso_d    = pick(load_w, i_lsb, len_eff, '0);
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                    done_d  = 1'b0;
                    abort_d = (cnt_q != '0);
                end else if (sample_edge) begin
                    // LSB-first inserts at len-1 so the word ends right-justified.
                    if (lsb_q)
                        rx_next = (rx_sh_q >> 1)
                                | (WIDTH'(mosi_s) << (len_q - FLW'(1)));
                    else
                        rx_next = {rx_sh_q[WIDTH-2:0], mosi_s};
                    sampled_d = 1'b1;
                    if (cnt_inc == len_q) begin
                        rx_push = 1'b1;
                        over_d  = ~rxf_ready;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        rx_sh_d = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                        rx_sh_d = rx_next;
                    end
                end else if (shift_edge && sampled_q) begin
                    // Unsampled shift edges are the CPHA=1 leading edge.
                    if (done_q) begin
                        tx_pop    = txf_valid;
                        under_d   = ~txf_valid;
                        tx_word_d = load_w;
                        miso_d    = pick(load_w, lsb_q, len_q, '0);
                        done_d    = 1'b0;
                        sampled_d = 1'b0;
                    end else begin
                        miso_d = pick(tx_word_q, lsb_q, len_q, cnt_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_reset) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
            done_d  = 1'b0;
            cnt_d   = '0;
            under_d = 1'b0;
            over_d  = 1'b0;
            abort_d = 1'b0;
            tx_pop  = 1'b0;
            rx_push = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            len_q     <= FLW'(WIDTH);
            cnt_q     <= '0;
            sampled_q <= 1'b0;
            done_q    <= 1'b0;
            tx_word_q <= '0;
            rx_sh_q   <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            under_q   <= 1'b0;
            over_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            sampled_q <= sampled_d;
            done_q    <= done_d;
            tx_word_q <= tx_word_d;
            rx_sh_q   <= rx_sh_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            under_q   <= under_d;
            over_q    <= over_d;
            abort_q   <= abort_d;
        end
    end

    assign o_miso        = miso_q;
    assign o_miso_oe     = oe_q;
    assign o_tx_underrun = under_q;
    assign o_rx_overrun  = over_q;
    assign o_frame_abort = abort_q;

    spi_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_reset),
        .i_data  (i_tx_data),
        .i_valid (i_tx_valid),
        .o_ready (o_tx_ready),
        .o_data  (txf_data),
        .o_valid (txf_valid),
        .i_ready (tx_pop),
        .o_level (o_tx_level)
    );

    spi_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_reset),
        .i_data  (rx_next),
        .i_valid (rx_push),
        .o_ready (rxf_ready),
        .o_data  (o_rx_data),
        .o_valid (o_rx_valid),
        .i_ready (i_rx_ready),
        .o_level (o_rx_level)
    );

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench for spi_slave_stream: a behavioural SPI master drives
// frames in several modes and the stream side is checked against constants.
module tb_spi_slave_stream;

    localparam int  WIDTH = 16;
    localparam int  DEPTH = 4;
    localparam int  LW    = 3;
    localparam int  FLW   = 5;
    localparam time TH    = 80;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sck = 1'b0;
    logic             mosi = 1'b0;
    logic             ss_n = 1'b1;
    logic             miso, miso_oe;
    logic             soft_rst = 1'b0;
    logic             cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
    logic [FLW-1:0]   frame_len = '0;
    logic [WIDTH-1:0] tx_data = '0;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready = 1'b0;
    logic [LW-1:0]    tx_level, rx_level;
    logic             underrun, overrun, abort;

    int n_vec = 0;
    int n_err = 0;
    int n_under = 0, n_over = 0, n_abort = 0;

    always #5 clk = ~clk;

    spi_slave_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sck         (sck),
        .i_mosi        (mosi),
        .i_ss_n        (ss_n),
        .o_miso        (miso),
        .o_miso_oe     (miso_oe),
        .i_reset       (soft_rst),
        .i_cpol        (cpol),
        .i_cpha        (cpha),
        .i_lsb         (lsb),
        .i_frame_len   (frame_len),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .o_rx_data     (rx_data),
        .o_rx_valid    (rx_valid),
        .i_rx_ready    (rx_ready),
        .o_tx_level    (tx_level),
        .o_rx_level    (rx_level),
        .o_tx_underrun (underrun),
        .o_rx_overrun  (overrun),
        .o_frame_abort (abort)
    );

    always @(posedge clk) begin
        if (underrun) n_under <= n_under + 1;
        if (overrun)  n_over  <= n_over + 1;
        if (abort)    n_abort <= n_abort + 1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_mode(input logic p, input logic h, input logic l,
                            input int len);
        cpol = p;
        cpha = h;
        lsb = l;
        frame_len = FLW'(len);
        sck = p;
        #(TH);
    endtask

    task automatic ss_lo();
        ss_n = 1'b0;
        #(TH);
    endtask

    task automatic ss_hi();
        #(TH);
        ss_n = 1'b1;
        #(2 * TH);
    endtask

    task automatic xfer(input int len, input int nbits,
                        input logic [WIDTH-1:0] tx,
                        output logic [WIDTH-1:0] rx);
        int b;
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            b = lsb ? i : len - 1 - i;
            if (!cpha) begin
                mosi = tx[b[3:0]];
                #(TH);
                sck = ~sck;
                rx[b[3:0]] = miso;
                #(TH);
                sck = ~sck;
            end else begin
                sck = ~sck;
                mosi = tx[b[3:0]];
                #(TH);
                sck = ~sck;
                rx[b[3:0]] = miso;
                #(TH);
            end
        end
    endtask

    task automatic frame(input int len, input logic [WIDTH-1:0] tx,
                         output logic [WIDTH-1:0] rx);
        ss_lo();
        xfer(len, len, tx, rx);
        ss_hi();
    endtask

    task automatic push_tx(input logic [WIDTH-1:0] w);
        @(negedge clk);
        tx_data = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    logic [WIDTH-1:0] m;
    int u0, o0, a0;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        settle();
        check("rst_oe", 64'(miso_oe), 64'd0);
        check("rst_miso", 64'(miso), 64'd0);
        check("rst_txrdy", 64'(tx_ready), 64'd1);
        check("rst_rxval", 64'(rx_valid), 64'd0);
        check("rst_txlvl", 64'(tx_level), 64'd0);
        check("rst_rxlvl", 64'(rx_level), 64'd0);

        // Mode 0, MSB first, 8 bits
        set_mode(1'b0, 1'b0, 1'b0, 8);
        push_tx(16'h00A5);
        check("t1_txlvl", 64'(tx_level), 64'd1);
        frame(8, 16'h003C, m);
        settle();
        check("t1_miso", 64'(m), 64'h00A5);
        check("t1_rxval", 64'(rx_valid), 64'd1);
        check("t1_rx", 64'(rx_data), 64'h003C);
        check("t1_rxlvl", 64'(rx_level), 64'd1);
        check("t1_oe_idle", 64'(miso_oe), 64'd0);
        pop_rx();
        check("t1_drain", 64'(rx_level), 64'd0);

        // Mode 3, LSB first, 12 bits
        set_mode(1'b1, 1'b1, 1'b1, 12);
        push_tx(16'h00F1);
        frame(12, 16'h0ABC, m);
        settle();
        check("t2_miso", 64'(m), 64'h00F1);
        check("t2_rx", 64'(rx_data), 64'h0ABC);
        pop_rx();

        // Length 0 selects the full width
        set_mode(1'b0, 1'b0, 1'b0, 0);
        push_tx(16'hBEEF);
        frame(16, 16'h1234, m);
        settle();
        check("len0_miso", 64'(m), 64'hBEEF);
        check("len0_rx", 64'(rx_data), 64'h1234);
        pop_rx();

        // Mode 1, three frames under one SS, two TX words queued
        set_mode(1'b0, 1'b1, 1'b0, 8);
        push_tx(16'h0011);
        push_tx(16'h0022);
        u0 = n_under;
        ss_lo();
        xfer(8, 8, 16'h0081, m);
        check("t3_miso0", 64'(m), 64'h0011);
        xfer(8, 8, 16'h0042, m);
        check("t3_miso1", 64'(m), 64'h0022);
        xfer(8, 8, 16'h0024, m);
        check("t3_miso2", 64'(m), 64'h0000);
        ss_hi();
        settle();
        check("t3_under", 64'(n_under - u0), 64'd1);
        check("t3_rxlvl", 64'(rx_level), 64'd3);
        check("t3_rx0", 64'(rx_data), 64'h0081);
        pop_rx();
        check("t3_rx1", 64'(rx_data), 64'h0042);
        pop_rx();
        check("t3_rx2", 64'(rx_data), 64'h0024);
        pop_rx();

        // RX overrun with DEPTH 4
        set_mode(1'b0, 1'b0, 1'b0, 8);
        for (int i = 1; i <= 4; i++) frame(8, WIDTH'(i), m);
        settle();
        check("t4_full", 64'(rx_level), 64'd4);
        o0 = n_over;
        frame(8, 16'h0077, m);
        settle();
        check("t4_over", 64'(n_over - o0), 64'd1);
        check("t4_rxlvl", 64'(rx_level), 64'd4);
        check("t4_head", 64'(rx_data), 64'h0001);
        for (int i = 1; i <= 4; i++) begin
            check("t4_drain", 64'(rx_data), 64'(i));
            pop_rx();
        end
        check("t4_empty", 64'(rx_valid), 64'd0);

        // Abort after 5 of 8 bits
        push_tx(16'h005A);
        a0 = n_abort;
        ss_lo();
        xfer(8, 5, 16'h00FF, m);
        #(TH);
        ss_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t5_oe", 64'(miso_oe), 64'd0);
        #(2 * TH);
        settle();
        check("t5_abort", 64'(n_abort - a0), 64'd1);
        check("t5_rxlvl", 64'(rx_level), 64'd0);
        push_tx(16'h00C3);
        frame(8, 16'h0096, m);
        settle();
        check("t5_miso", 64'(m), 64'h00C3);
        check("t5_rx", 64'(rx_data), 64'h0096);
        pop_rx();

        // Async reset mid-frame, both FIFOs at level 3
        for (int i = 0; i < 3; i++) frame(8, 16'h0055, m);
        for (int i = 0; i < 4; i++) push_tx(16'h00AA);
        ss_lo();
        xfer(8, 3, 16'h0000, m);
        @(negedge clk);
        check("t6_txlvl", 64'(tx_level), 64'd3);
        check("t6_rxlvl", 64'(rx_level), 64'd3);
        check("t6_oe", 64'(miso_oe), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6a_txlvl", 64'(tx_level), 64'd0);
        check("t6a_rxlvl", 64'(rx_level), 64'd0);
        check("t6a_oe", 64'(miso_oe), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ss_hi();
        settle();

        // Soft reset mid-frame
        for (int i = 0; i < 3; i++) frame(8, 16'h0033, m);
        for (int i = 0; i < 4; i++) push_tx(16'h00CC);
        ss_lo();
        xfer(8, 3, 16'h0000, m);
        @(negedge clk);
        check("t6s_txlvl", 64'(tx_level), 64'd3);
        check("t6s_rxlvl", 64'(rx_level), 64'd3);
        soft_rst = 1'b1;
        #1;
        check("t6s_sync", 64'(miso_oe), 64'd1);
        @(negedge clk);
        soft_rst = 1'b0;
        check("t6s_oe", 64'(miso_oe), 64'd0);
        check("t6s_txlvl0", 64'(tx_level), 64'd0);
        check("t6s_rxlvl0", 64'(rx_level), 64'd0);
        check("t6s_txrdy", 64'(tx_ready), 64'd1);
        ss_hi();
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_stream.md
Name: spi_slave_stream

Overview:
Next-generation SPI slave with run-time mode selection (CPOL/CPHA/bit order), programmable frame length up to WIDTH, and TX/RX FIFOs with valid/ready streaming interfaces. It lets the system side queue outgoing words and drain received words without servicing an interrupt every frame. Back-to-back frames under one continuous slave select are supported. It sits between the pad-level SPI pins and an internal bus bridge/DMA.

Parameters:
WIDTH, 8, maximum frame width in bits (8..64).
DEPTH, 16, entries per FIFO; power of two, 2..256.
LW, $clog2(DEPTH)+1, level-output width (derived, not overridable).

Ports:
i_clk  in  1  system clock; i_clk must be at least 8x SCK frequency
i_rst_n  in  1  asynchronous active-low reset
i_sck  in  1  SPI clock (asynchronous)
i_mosi  in  1  master-out data (asynchronous)
i_ss_n  in  1  slave select, active low (asynchronous)
o_miso  out  1  master-in data
o_miso_oe  out  1  MISO output enable
i_reset  in  1  synchronous soft reset: flushes FIFOs, returns FSM to IDLE
i_cpol  in  1  clock idle level; latched at frame-group start
i_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched
i_lsb  in  1  1 = LSB first; latched
i_frame_len  in  $clog2(WIDTH)+1  bits per frame; 0 or >WIDTH treated as WIDTH; latched
i_tx_data  in  WIDTH  TX word, right-justified
i_tx_valid  in  1  TX push request
o_tx_ready  out  1  high when the TX FIFO is not full
o_rx_data  out  WIDTH  RX FIFO head, right-justified, zero-extended
o_rx_valid  out  1  high when the RX FIFO is not empty (first-word fall-through)
i_rx_ready  in  1  RX pop
o_tx_level  out  LW  TX FIFO occupancy
o_rx_level  out  LW  RX FIFO occupancy
o_tx_underrun  out  1  one-cycle pulse: frame started with TX FIFO empty
o_rx_overrun  out  1  one-cycle pulse: frame received with RX FIFO full; word dropped
o_frame_abort  out  1  one-cycle pulse: SS deasserted mid-frame

Behaviour:
- Reset (async, or i_reset): o_miso=0, o_miso_oe=0, all pulses 0, FIFOs empty, o_tx_ready=1, o_rx_valid=0, levels 0. SS synchroniser resets to 11; SCK and MOSI synchronisers reset to 00.
- i_sck, i_mosi and i_ss_n each pass through a 2-flop synchroniser. Edges are detected on stage 2 against a stage-3 history flop. MOSI is taken from its stage 2 so it stays aligned with SCK.
- Sample edge is rising when CPOL^CPHA=0, otherwise falling. The shift edge is the opposite edge.
- FSM states:
  - IDLE -> ACTIVE on synchronised SS falling: latch mode and length, bit_cnt=0, sampled=0, o_miso_oe=1. Pop the TX FIFO if non-empty, else load 0 and pulse o_tx_underrun. Drive o_miso with first bit (bit0 if LSB, else bit[len-1]).
  - ACTIVE, sample edge: shift MOSI into the RX shifter, sampled=1, bit_cnt++. When bit_cnt reaches len: push the RX word (pulse o_rx_overrun instead if full), bit_cnt=0, set frame_done.
  - ACTIVE, shift edge: if sampled=0, ignore (CPHA=1 first leading edge). If frame_done, load the next TX word (same pop/underrun rule), drive its first bit, and clear frame_done and sampled. Otherwise drive the next bit.
  - ACTIVE -> IDLE on SS rising: o_miso_oe=0 and o_miso=0 next cycle. If 0<bit_cnt<len, pulse o_frame_abort and discard the partial RX word. A TX word popped for a frame that never completed is lost.
- Mode inputs are ignored while ACTIVE.
- FIFO simultaneous push and pop when full or empty: both succeed only when legal. Push when full is ignored on the system side; o_tx_ready is already low. Occupancy is unchanged on a simultaneous push and pop.
- Latency: o_rx_valid rises at most 4 i_clk cycles after the final sample SCK edge. o_miso changes at most 4 i_clk cycles after a shift SCK edge.
- Async reset mid-frame: immediate return to reset values. Master-side corruption is acceptable.

Decomposition:
- Package spi_pkg holds the SS/SCK sync reset constants, the FSM state encoding (IDLE, ACTIVE), and the frame-length clamp function.
- One sub-module, spi_sync_fifo (WIDTH, DEPTH; valid/ready; level output), instantiated twice.

Test Plan:
1. Mode 0, MSB, len 8: TX 0xA5 queued; master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; o_rx_data=0x3C, o_rx_level=1.
2. Mode 3, LSB, len 12, WIDTH 16: TX 0x0F1 -> MISO LSB-first 1,0,0,0,1,1,1,1,0,0,0,0; RX 0xABC stored as 0x0ABC.
3. Mode 1, three back-to-back frames under one SS, TX FIFO has 0x11,0x22 -> third frame MISO=0x00 and one o_tx_underrun pulse; RX receives 3 words.
4. RX FIFO DEPTH=4 full, no i_rx_ready, fifth frame 0x77 -> o_rx_overrun pulse, level stays 4, head unchanged.
5. SS raised after 5 bits of an 8-bit frame -> o_frame_abort pulse, no RX push, o_miso_oe=0 within 4 cycles; next frame correct.
6. i_rst_n low mid-frame with both FIFOs at level 3 -> levels 0, o_miso_oe=0 asynchronously; i_reset same but synchronous.
